// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle RV32I controller:
//   - state_t     : 4-bit FSM state encoding (FETCH is 4'd0)
//   - OP_*        : RV32I major opcodes recognised by the decoder
//   - IMM_*       : Imm_Src encodings for the immediate extender
//   - ALU_*       : ALUControl encodings
//   - RES_*       : ResultSrc encodings
//   - SRCA_*/SRCB_: ALU operand select encodings
//   - alu_mode_t  : how the ALU decoder should choose ALUControl
//   - branch_taken: branch condition from Funct3 and the ALU flags
// Optional feature macro used by the controller: ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALWB    = 4'd12,
    S_LUI      = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_mode_t;

  // Branch condition: the datapath subtracts rd1-rd2, so Zero means equal and
  // Neg means signed less-than. Unsupported Funct3 values never branch.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       zero,
                                        input logic       neg);
    logic taken;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = neg;
      3'b101:  taken = ~neg;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALUControl selection for the multi-cycle controller.
// Ports:
//   i_funct3      in  3  instruction[14:12]
//   i_funct7b5    in  1  instruction[30]
//   i_op5         in  1  Op[5]; 1 for R-type, 0 for I-type ALU ops
//   i_mode        in  2  forced add, forced sub, or decode from funct fields
//   o_alu_control out 3  ALUControl encoding
// -----------------------------------------------------------------------------
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic      [2:0] i_funct3,
  input  logic            i_funct7b5,
  input  logic            i_op5,
  input  alu_mode_t       i_mode,
  output logic      [2:0] o_alu_control
);

  // Map the requested ALU mode and funct fields onto an ALU operation.
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_mode)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Only R-type uses bit 30 to select sub; addi ignores it.
          3'b000: begin
            if (i_op5 && i_funct7b5) begin
              o_alu_control = ALU_SUB;
            end else begin
              o_alu_control = ALU_ADD;
            end
          end
          3'b111:  o_alu_control = ALU_AND;
          3'b110:  o_alu_control = ALU_OR;
          3'b100:  o_alu_control = ALU_XOR;
          3'b010:  o_alu_control = ALU_SLT;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// multi_cycle_controller
// Control FSM for the multi-cycle RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback; all datapath selects are decoded from the
// current state (plus funct fields / flags), only the retired-instruction
// counter is registered.
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes in a HALT
// state (adds the Illegal output); otherwise unknown opcodes act as NOPs.
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   Op, Funct3, Funct7b5  instruction fields from the IR
//   Zero, Neg             ALU flags
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   RegWrite, Imm_Src, ALUControl   datapath controls
//   Retired               completed-instruction count (wraps)
//   State                 current FSM state (debug)
//   Illegal               HALT indicator (ILLEGAL_TRAP_EN only)
// -----------------------------------------------------------------------------
module multi_cycle_controller
  import ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic             Funct7b5,
  input  logic             Zero,
  input  logic             Neg,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic [2:0]       Imm_Src,
  output logic [2:0]       ALUControl,
  output logic [CNT_W-1:0] Retired,
  output logic [3:0]       State
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             Illegal
`endif
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_retired;
  alu_mode_t        w_alu_mode;
  logic             w_pc_write;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_reg_write;

  alu_decoder u_alu_decoder (
    .i_funct3      (Funct3),
    .i_funct7b5    (Funct7b5),
    .i_op5         (Op[5]),
    .i_mode        (w_alu_mode),
    .o_alu_control (ALUControl)
  );

  // Next-state selection.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_LUI:            w_next_state = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next_state = S_HALT;
`else
          default:           w_next_state = S_FETCH;
`endif
        endcase
      end
      // Op[5] separates store (0100011) from load (0000011).
      S_MEMADR: begin
        if (Op[5]) begin
          w_next_state = S_MEMWRITE;
        end else begin
          w_next_state = S_MEMREAD;
        end
      end
      S_MEMREAD:  w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = S_FETCH;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_ALUWB;
      S_JALR:     w_next_state = S_JALWB;
      S_JALWB:    w_next_state = S_FETCH;
      S_LUI:      w_next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:     w_next_state = S_HALT;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Decode datapath selects from the current state.
  always_comb begin
    w_pc_write  = 1'b0;
    AdrSrc      = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    w_reg_write = 1'b0;
    Imm_Src     = IMM_I;
    w_alu_mode  = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        w_pc_write = 1'b1;
      end
      // Branch/jump target is computed speculatively into ALUOut here.
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (Op == OP_JAL) begin
          Imm_Src = IMM_J;
        end else begin
          Imm_Src = IMM_B;
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        if (Op[5]) begin
          Imm_Src = IMM_S;
        end else begin
          Imm_Src = IMM_I;
        end
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RD1;
        w_alu_mode = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        w_alu_mode = ALUOP_FUNCT;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        w_alu_mode = ALUOP_SUB;
        w_pc_write = branch_taken(Funct3, Zero, Neg);
      end
      // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        w_pc_write = 1'b1;
        Imm_Src    = IMM_J;
      end
      S_JALR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        w_pc_write = 1'b1;
      end
      S_JALWB: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_reg_write = 1'b1;
      end
      S_LUI: begin
        Imm_Src     = IMM_U;
        ResultSrc   = RES_IMMEXT;
        w_reg_write = 1'b1;
      end
      default: begin
        w_pc_write = 1'b0;
      end
    endcase
  end

  // Reset suppresses every write enable so an aborted instruction has no effect.
  always_comb begin
    if (!rst_n) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end else begin
      PCWrite  = w_pc_write;
      MemWrite = w_mem_write;
      IRWrite  = w_ir_write;
      RegWrite = w_reg_write;
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= state_t'(RESET_STATE);
      r_retired <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      // FETCH never follows FETCH, so this counts each instruction end once.
      if (w_next_state == S_FETCH) begin
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  assign Retired = r_retired;
  assign State   = r_state;
`ifdef ILLEGAL_TRAP_EN
  assign Illegal = (r_state == S_HALT);
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_controller
// Self-checking bench: for every instruction a reference model lists the
// expected control bundle for each cycle, derived from the instruction class.
// Honours ILLEGAL_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       regw;
    logic [2:0] imm;
    logic [2:0] alu;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic        Funct7b5;
  logic        Zero;
  logic        Neg;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  Imm_Src, ALUControl;
  logic [31:0] Retired;
  logic [3:0]  State;
`ifdef ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  int   n_checks = 0;
  int   n_fails  = 0;
  int   exp_retired = 0;
  ctl_t ph[$];
  bit   is_illegal;
  logic [16:0] obs_ctl;

  assign obs_ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, RegWrite, Imm_Src, ALUControl};

  multi_cycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Zero(Zero), .Neg(Neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .Imm_Src(Imm_Src), .ALUControl(ALUControl), .Retired(Retired),
    .State(State)
`ifdef ILLEGAL_TRAP_EN
    , .Illegal(Illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t mk(input logic pcw, input logic adr, input logic memw,
                              input logic irw, input logic [1:0] res,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic regw, input logic [2:0] imm,
                              input logic [2:0] alu);
    ctl_t c;
    c = {pcw, adr, memw, irw, res, sa, sb, regw, imm, alu};
    return c;
  endfunction

  function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic is_r, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic br_fn(input logic [2:0] f3, input logic z, input logic n);
    logic flag;
    flag = f3[2] ? n : z;
    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101)
      return f3[0] ? ~flag : flag;
    return 1'b0;
  endfunction

  // Expected per-cycle control bundles for one instruction, FETCH first.
  task automatic plan(input logic [31:0] ins, input logic z, input logic n);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
    ph.delete();
    is_illegal = 1'b0;
    ph.push_back(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b000, 3'b000));
    ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0,
                    (op == 7'b1101111) ? 3'b100 : 3'b010, 3'b000));
    case (op)
      7'b0000011: begin
        ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b000));
        ph.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000));
        ph.push_back(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000));
      end
      7'b0100011: begin
        ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b001, 3'b000));
        ph.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000));
      end
      7'b0110011: begin
        ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b000, alu_fn(f3, 1'b1, f7)));
        ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000));
      end
      7'b0010011: begin
        ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, alu_fn(f3, 1'b0, f7)));
        ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000));
      end
      7'b1100011:
        ph.push_back(mk(br_fn(f3, z, n), 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b000, 3'b001));
      7'b1101111: begin
        ph.push_back(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b100, 3'b000));
        ph.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000));
      end
      7'b1100111: begin
        ph.push_back(mk(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 0, 3'b000, 3'b000));
        ph.push_back(mk(0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 1, 3'b000, 3'b000));
      end
      7'b0110111:
        ph.push_back(mk(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 3'b011, 3'b000));
      default: is_illegal = 1'b1;
    endcase
  endtask

  // Runs one instruction from its FETCH cycle; entered and left at posedge+1.
  task automatic run_instr(input logic [31:0] ins, input logic z, input logic n);
    Op = ins[6:0]; Funct3 = ins[14:12]; Funct7b5 = ins[30]; Zero = z; Neg = n;
    plan(ins, z, n);
    chk($sformatf("retired ins=%h", ins), Retired, exp_retired);
    for (int i = 0; i < ph.size(); i++) begin
      #1;
      chk($sformatf("ctl ins=%h ph%0d", ins, i), obs_ctl, ph[i]);
      chk($sformatf("fetch_state ins=%h ph%0d", ins, i), State == 4'd0, i == 0);
      @(posedge clk); #1;
    end
`ifdef ILLEGAL_TRAP_EN
    if (is_illegal) begin
      repeat (10) begin
        #1;
        chk("halt_ctl", obs_ctl, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000));
        chk("halt_illegal", Illegal, 1'b1);
        chk("halt_not_fetch", State != 4'd0, 1'b1);
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_retired = 0;
      chk("halt_reset_state", State, 4'd0);
    end else begin
      exp_retired++;
    end
`else
    exp_retired++;
`endif
  endtask

  logic [6:0] legal_ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    logic [31:0] rins;
    rst_n = 1'b0; Op = 7'd0; Funct3 = 3'd0; Funct7b5 = 1'b0; Zero = 1'b0; Neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", obs_ctl, mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b000, 3'b000));
    chk("rst_state", State, 4'd0);
    chk("rst_retired", Retired, 32'd0);
    rst_n = 1'b1;

    run_instr(32'h002081B3, 1'b0, 1'b0);   // add
    run_instr(32'h0000A183, 1'b0, 1'b0);   // lw
    run_instr(32'h00208463, 1'b1, 1'b0);   // beq taken
    run_instr(32'h00208463, 1'b0, 1'b1);   // beq not taken
    run_instr(32'h0020C463, 1'b0, 1'b1);   // blt taken
    run_instr(32'h0020A463, 1'b1, 1'b1);   // unsupported funct3
    run_instr(32'h008000EF, 1'b0, 1'b0);   // jal
    run_instr(32'h402081B3, 1'b0, 1'b0);   // sub
    run_instr(32'h40000093, 1'b0, 1'b0);   // addi with bit30 set stays add
    run_instr(32'h000080E7, 1'b0, 1'b0);   // jalr
    run_instr(32'h123450B7, 1'b0, 1'b0);   // lui
    run_instr(32'h0020A023, 1'b0, 1'b0);   // sw

    for (int k = 0; k < 40; k++) begin
      rins = $urandom;
      rins[6:0] = legal_ops[$urandom_range(0, 7)];
      run_instr(rins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    run_instr(32'h0000007F, 1'b0, 1'b0);   // unknown opcode

    // Reset in the middle of a store.
    Op = 7'b0100011; Funct3 = 3'b010; Funct7b5 = 1'b0; Zero = 1'b0; Neg = 1'b0;
    plan(32'h0020A023, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("abort_ctl ph%0d", i), obs_ctl, ph[i]);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_memwrite", obs_ctl, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_retired = 0;
    chk("abort_state", State, 4'd0);
    chk("abort_retired", Retired, 32'd0);

    run_instr(32'h002081B3, 1'b0, 1'b0);
    chk("final_retired", Retired, exp_retired);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
